vco_phase_decimator: RTL and testbench

VCO_PHASE_DECIMATOR -- requirements
Module: vco_phase_decimator

---
 rtl/vco_adc_pkg.sv | 18 +
 rtl/cic2_decim.sv | 47 ++++
 rtl/vco_phase_decimator.sv | 135 +++++++++++++
 tb/tb_vco_phase_decimator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vco_adc_pkg.sv
// Shared FSM encoding, parameter defaults and helpers for the VCO-based ADC front end.
package vco_adc_pkg;

  localparam int PHASE_WIDTH_DEF  = 11;
  localparam int OSR_LOG2_MAX_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_SETTLE,
    ST_RUN
  } state_e;

  function automatic logic [3:0] clamp_osr(input logic [3:0] v, input int unsigned max_v);
    return (32'(v) > max_v) ? 4'(max_v) : v;
  endfunction

endpackage

// File: rtl/cic2_decim.sv
// Second-order CIC decimator fed by VCO phase differences; c2_o is valid on tick_i.
module cic2_decim #(
  parameter int PHASE_WIDTH = 11,
  parameter int OUT_WIDTH   = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   load_i,
  input  logic                   integ_i,
  input  logic                   tick_i,
  input  logic [PHASE_WIDTH-1:0] p_in_i,
  output logic [OUT_WIDTH-1:0]   c2_o
);

  logic [PHASE_WIDTH-1:0] p_prev_q;
  logic [PHASE_WIDTH-1:0] d;
  logic [OUT_WIDTH-1:0]   i1_q, i2_q, i2_z_q, c1_z_q, c1;

  // Phase difference wraps naturally at the counter width.
  always_comb begin
    d    = p_in_i - p_prev_q;
    c1   = i2_q - i2_z_q;
    c2_o = c1 - c1_z_q;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      p_prev_q <= '0;
      i1_q     <= '0;
      i2_q     <= '0;
      i2_z_q   <= '0;
      c1_z_q   <= '0;
    end else begin
      if (load_i || integ_i) p_prev_q <= p_in_i;
      if (integ_i) begin
        i1_q <= i1_q + {{(OUT_WIDTH-PHASE_WIDTH){1'b0}}, d};
        i2_q <= i2_q + i1_q;
      end
      if (tick_i) begin
        i2_z_q <= i2_q;
        c1_z_q <= c1;
      end
    end
  end

endmodule

// File: rtl/vco_phase_decimator.sv
// VCO phase-to-sample decimator: sequencing FSM, decimation counter and output handshake
// around a single cic2_decim datapath.
module vco_phase_decimator
  import vco_adc_pkg::*;
#(
  parameter int PHASE_WIDTH  = PHASE_WIDTH_DEF,
  parameter int OSR_LOG2_MAX = OSR_LOG2_MAX_DEF,
  parameter int OUT_WIDTH    = PHASE_WIDTH + 2*OSR_LOG2_MAX
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   vco_enb,
  input  logic [PHASE_WIDTH-1:0] p_in,
  input  logic [3:0]             osr_log2,
  output logic [OUT_WIDTH-1:0]   dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   overrun
);

  localparam logic [OSR_LOG2_MAX-1:0] CNT_ONE  = 1;
  localparam logic [OSR_LOG2_MAX-1:0] CNT_ONES = '1;

  state_e                  state_q, state_d;
  logic [3:0]              osr_q, osr_d;
  logic [OSR_LOG2_MAX-1:0] cnt_q, cnt_d, cnt_mask;
  logic                    settle_q, settle_d;
  logic                    vco_enb_q;
  logic [OUT_WIDTH-1:0]    dout_q, dout_d, c2;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    clr, load_prev, integ, tick, new_sample;

  cic2_decim #(
    .PHASE_WIDTH(PHASE_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_cic (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .load_i (load_prev),
    .integ_i(integ),
    .tick_i (tick),
    .p_in_i (p_in),
    .c2_o   (c2)
  );

  assign cnt_mask = CNT_ONES >> (OSR_LOG2_MAX - int'(osr_q));

  always_comb begin
    state_d   = state_q;
    osr_d     = osr_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    clr       = 1'b0;
    load_prev = 1'b0;
    integ     = 1'b0;
    tick      = 1'b0;
    if (!en) begin
      state_d  = ST_IDLE;
      clr      = 1'b1;
      cnt_d    = '0;
      settle_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
          osr_d   = clamp_osr(osr_log2, OSR_LOG2_MAX);
        end
        ST_PRIME: begin
          load_prev = 1'b1;
          state_d   = ST_SETTLE;
        end
        default: begin
          integ = 1'b1;
          tick  = (cnt_q == cnt_mask);
          cnt_d = tick ? '0 : cnt_q + CNT_ONE;
          // settle_q marks the first discarded tick; the second one enters RUN.
          if (state_q == ST_SETTLE && tick) begin
            settle_d = !settle_q;
            if (settle_q) state_d = ST_RUN;
          end
        end
      endcase
    end
  end

  assign new_sample = tick && (state_q == ST_RUN);

  always_comb begin
    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (new_sample) begin
      if (!valid_q || dout_ready) begin
        dout_d  = c2;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
    if (!en) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      osr_q     <= '0;
      cnt_q     <= '0;
      settle_q  <= 1'b0;
      vco_enb_q <= 1'b1;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      osr_q     <= osr_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      vco_enb_q <= ~en;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign vco_enb    = vco_enb_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_vco_phase_decimator.sv
// Self-checking bench: constant-step vector table, handshake/enable/reset sequences and
// random phase streams compared against a double-difference CIC reference model.
module tb_vco_phase_decimator;

  localparam int PW = 11;
  localparam int OW = 31;

  logic          clk = 1'b0;
  logic          rst, en, vco_enb, dout_valid, dout_ready, overrun;
  logic [PW-1:0] p_in;
  logic [3:0]    osr_log2;
  logic [OW-1:0] dout;

  int tests = 0;
  int fails = 0;

  int          step_v;
  bit          rand_mode;
  logic [PW-1:0] hist[$];

  typedef struct {
    int     osr;
    int     r;
    int     start;
    int     step;
    longint exp;
    int     nsamp;
  } vec_t;

  vec_t tbl[6];

  vco_phase_decimator #(
    .PHASE_WIDTH (11),
    .OSR_LOG2_MAX(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .vco_enb   (vco_enb),
    .p_in      (p_in),
    .osr_log2  (osr_log2),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .overrun   (overrun)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: remember the phase presented at this edge, then advance the phase source.
  task automatic cyc();
    hist.push_back(p_in);
    @(posedge clk);
    #1;
    if (rand_mode) p_in = p_in + PW'($urandom);
    else           p_in = p_in + PW'(step_v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_vco_enb", 64'(vco_enb), 1);
    chk("rst_dout", 64'(dout), 0);
    chk("rst_valid", 64'(dout_valid), 0);
    chk("rst_overrun", 64'(overrun), 0);
  endtask

  task automatic run_stream(input int osr_in, input int r, input int start, input int step,
                            input bit rnd, input int nsamp, input bit chk_const,
                            input longint cval, input bit do_rst, input string nm);
    int            ncyc;
    int            got_edge[$];
    logic [OW-1:0] got_val[$];
    longint        s[$];
    longint        u1, u2, ev;
    logic [PW-1:0] prev, dlt;
    int            nexp;
    if (do_rst) do_reset();
    hist.delete();
    p_in       = PW'(start);
    step_v     = step;
    rand_mode  = rnd;
    dout_ready = 1'b1;
    osr_log2   = 4'(osr_in);
    en         = 1'b1;
    ncyc       = (nsamp + 2) * r + 3;
    for (int e = 1; e <= ncyc; e++) begin
      cyc();
      if (e == 1) osr_log2 = 4'($urandom);
      if (e == 2) chk({nm, "_vco_enb_low"}, 64'(vco_enb), 0);
      if (dout_valid) begin
        got_edge.push_back(e);
        got_val.push_back(dout);
      end
    end
    // Model: i2 before each tick cycle, then second difference across ticks.
    u1   = 0;
    u2   = 0;
    prev = hist[1];
    for (int n = 0; 2 + n < hist.size(); n++) begin
      if ((n + 1) % r == 0) s.push_back(u2);
      dlt  = hist[2+n] - prev;
      prev = hist[2+n];
      u2   = u2 + u1;
      u1   = u1 + longint'(dlt);
    end
    nexp = (s.size() > 2) ? s.size() - 2 : 0;
    chk({nm, "_count"}, 64'(got_val.size()), 64'(nexp));
    for (int k = 0; k < nexp && k < got_val.size(); k++) begin
      ev = (s[k+2] - 2 * s[k+1] + s[k]) & 64'h7FFF_FFFF;
      chk($sformatf("%s_val%0d", nm, k), 64'(got_val[k]), 64'(ev));
      chk($sformatf("%s_edge%0d", nm, k), 64'(got_edge[k]), 64'((k + 3) * r + 2));
      if (chk_const) chk($sformatf("%s_const%0d", nm, k), 64'(got_val[k]), 64'(cval));
    end
  endtask

  initial begin
    int e;
    bit found;
    rst        = 1'b1;
    en         = 1'b0;
    p_in       = '0;
    osr_log2   = '0;
    dout_ready = 1'b1;
    step_v     = 0;
    rand_mode  = 1'b0;

    tbl[0] = '{osr: 2,  r: 4,    start: 0,    step: 3,    exp: 48,         nsamp: 4};
    tbl[1] = '{osr: 3,  r: 8,    start: 2040, step: 5,    exp: 320,        nsamp: 4};
    tbl[2] = '{osr: 10, r: 1024, start: 7,    step: 2047, exp: 2146435072, nsamp: 1};
    tbl[3] = '{osr: 0,  r: 1,    start: 100,  step: 7,    exp: 7,          nsamp: 5};
    tbl[4] = '{osr: 12, r: 1024, start: 0,    step: 1,    exp: 1048576,    nsamp: 1};
    tbl[5] = '{osr: 1,  r: 2,    start: 55,   step: 0,    exp: 0,          nsamp: 3};

    do_reset();
    for (int i = 0; i < 6; i++)
      run_stream(tbl[i].osr, tbl[i].r, tbl[i].start, tbl[i].step, 1'b0, tbl[i].nsamp,
                 1'b1, tbl[i].exp, 1'b1, $sformatf("vec%0d", i));

    // Enable dropped mid-RUN, then re-enabled: full settle latency again.
    run_stream(2, 4, 100, 3, 1'b0, 2, 1'b1, 48, 1'b1, "pre_drop");
    en = 1'b0;
    cyc();
    chk("drop_vco_enb", 64'(vco_enb), 1);
    chk("drop_valid", 64'(dout_valid), 0);
    cyc();
    run_stream(2, 4, 9, 3, 1'b0, 2, 1'b1, 48, 1'b0, "reenable");

    // Reset mid-RUN with en held high.
    rst = 1'b1;
    cyc();
    chk("mrst_vco_enb", 64'(vco_enb), 1);
    chk("mrst_dout", 64'(dout), 0);
    chk("mrst_valid", 64'(dout_valid), 0);
    chk("mrst_overrun", 64'(overrun), 0);
    rst = 1'b0;
    run_stream(3, 8, 0, 5, 1'b0, 2, 1'b1, 320, 1'b0, "after_rst");

    // Back-pressure: first sample held, later ones dropped, overrun sticky.
    do_reset();
    hist.delete();
    p_in       = '0;
    step_v     = 1;
    rand_mode  = 1'b0;
    osr_log2   = 4'd2;
    dout_ready = 1'b0;
    en         = 1'b1;
    e          = 0;
    found      = 1'b0;
    while (!found && e < 100) begin
      cyc();
      e++;
      if (dout_valid) found = 1'b1;
    end
    chk("ovr_first_edge", 64'(e), 14);
    chk("ovr_first_val", 64'(dout), 16);
    chk("ovr_clear_before", 64'(overrun), 0);
    repeat (8) cyc();
    chk("ovr_hold_val", 64'(dout), 16);
    chk("ovr_hold_valid", 64'(dout_valid), 1);
    chk("ovr_flag", 64'(overrun), 1);
    dout_ready = 1'b1;
    cyc();
    chk("ovr_release_valid", 64'(dout_valid), 0);
    chk("ovr_release_flag", 64'(overrun), 1);
    en = 1'b0;
    cyc();
    chk("ovr_retained_en0", 64'(overrun), 1);
    dout_ready = 1'b1;

    // Random phase increments, several ratios including R=1 (replace-on-ready every cycle).
    for (int t = 0; t < 5; t++) begin
      int o;
      o = (t == 0) ? 0 : int'($urandom_range(0, 4));
      run_stream(o, 1 << o, int'($urandom_range(0, 2047)), 0, 1'b1, 6, 1'b0, 0, 1'b1,
                 $sformatf("rand%0d", t));
      chk($sformatf("rand%0d_no_overrun", t), 64'(overrun), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
